instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the halfword-aligned start address loaded on reset and on restart.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of FETCH cycles waited for imem_valid_i before error.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1, begins fetching from IDLE or HALT.
REQ-006 SHALL have port imem_req_o, output, 1, instruction memory read request.
REQ-007 SHALL have port imem_addr_o, output, 16, byte address of the requested halfword.
REQ-008 SHALL have port imem_rdata_i, input, 16, instruction word, valid when imem_valid_i=1.
REQ-009 SHALL have port imem_valid_i, input, 1, read data strobe.
REQ-010 SHALL have port cu_instr_o, output, 16, instruction word driven to the control unit.
REQ-011 SHALL have port cu_input_en_o, output, 1, qualifies cu_instr_o for one decode cycle.
REQ-012 SHALL have port stall_i, input, 1, downstream busy; holds the current issue.
REQ-013 SHALL have port branch_i, input, 1, taken-branch indication from the control unit.
REQ-014 SHALL have port branch_target_i, input, 16, redirect address.
REQ-015 SHALL have port self_instruct_i, input, 16, control-unit-generated follow-up instruction.
REQ-016 SHALL have port self_instruct_en_i, input, 1, requests injection of self_instruct_i.
REQ-017 SHALL have port end_program_i, input, 1, decoded all-zero instruction; stop.
REQ-018 SHALL have port pc_o, output, 16, current fetch PC.
REQ-019 SHALL have port instr_count_o, output, 16, number of decodes completed.
REQ-020 SHALL have port halted_o, output, 1, high in HALT.
REQ-021 SHALL have port err_o, output, 1, sticky error flag.

Function
REQ-022 SHALL implement states IDLE, FETCH, ISSUE, INJECT, HALT.
REQ-023 SHALL, in IDLE or HALT with start_i=1, load pc=RESET_PC, clear err_o and instr_count_o, and go to FETCH.
REQ-024 SHALL, in FETCH, drive imem_req_o=1 and imem_addr_o=pc every cycle until imem_valid_i=1, then capture imem_rdata_i into the instruction register, set pc=pc+2 (wrapping 16'hFFFE -> 16'h0000), and go to ISSUE.
REQ-025 SHALL, if imem_valid_i stays 0 for MEM_TIMEOUT consecutive FETCH cycles, set err_o=1 and go to HALT.
REQ-026 SHALL ignore imem_valid_i in every state except FETCH.
REQ-027 SHALL, in ISSUE with stall_i=1, hold the instruction register and drive cu_input_en_o=0.
REQ-028 SHALL, in ISSUE with stall_i=0, drive cu_input_en_o=1 and cu_instr_o=instruction register for exactly one cycle, sample the control-unit responses in the same cycle, and increment instr_count_o (wrapping).
REQ-029 SHALL resolve same-cycle responses in ISSUE with priority end_program_i (go to HALT) > self_instruct_en_i (latch self_instruct_i, go to INJECT) > branch_i (pc=branch_target_i with bit0 forced 0, go to FETCH) > none (go to FETCH).
REQ-030 SHALL, in INJECT, obey the same stall and one-cycle issue rules as ISSUE, using the latched self-instruction, and increment instr_count_o.
REQ-031 SHALL, in INJECT, ignore end_program_i, set err_o=1 on self_instruct_en_i=1 (nesting is not allowed) without re-injecting, honour branch_i as in ISSUE, and go to FETCH.
REQ-032 SHALL drive cu_instr_o=0 whenever cu_input_en_o=0, and imem_req_o=0 outside FETCH.
REQ-033 SHALL, in HALT, hold pc, drive halted_o=1, and keep all request and enable outputs at 0.

Reset
REQ-034 SHALL, on rst_n_i=0 at any time including mid-fetch or mid-inject, immediately enter IDLE with pc=RESET_PC, instruction and self-instruction registers=0, instr_count_o=0, and all outputs 0.
REQ-035 SHALL leave IDLE only on start_i after reset is released.

Verification
REQ-036 SHALL cover: start_i, memory returns 16'h2005 after 2 wait cycles -> imem_req_o high 3 cycles at addr 0, one cu_input_en_o pulse with 16'h2005, pc=2, next fetch at addr 2.
REQ-037 SHALL cover: branch_i=1 and branch_target_i=16'h0041 in ISSUE -> next imem_addr_o=16'h0040, instr_count_o+1.
REQ-038 SHALL cover: push decode with self_instruct_en_i=1 and self_instruct_i=16'h9701 -> INJECT issues 16'h9701 on the next cu_input_en_o pulse, then fetch resumes at pc.
REQ-039 SHALL cover: stall_i high 3 cycles in ISSUE -> cu_input_en_o low 3 cycles, then a single pulse; end_program_i and branch_i together -> HALT, halted_o=1, no further imem_req_o.
REQ-040 SHALL cover: imem_valid_i never asserted -> err_o=1 and halted_o=1 after 16 FETCH cycles; rst_n_i low during INJECT -> all outputs 0 asynchronously, pc=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches 16-bit instructions from a halfword-addressed instruction memory and
// hands them one at a time to the control unit. The control unit answers each
// issued instruction in the same cycle: it can stop the program, ask for one
// self-generated follow-up instruction to be injected, or redirect the PC.
//
// Handshakes (all strobes are single-cycle and sampled on the rising edge):
//   - Memory: imem_req_o/imem_addr_o are held every FETCH cycle until the
//     cycle in which imem_valid_i=1; that cycle transfers imem_rdata_i. A strobe
//     seen while imem_req_o=0 transfers nothing.
//   - Control unit: cu_input_en_o=1 marks the single cycle in which cu_instr_o
//     is consumed; stall_i=1 holds that offer back (cu_input_en_o stays 0).
//     end_program_i / self_instruct_en_i / branch_i are only meaningful in the
//     cycle where cu_input_en_o=1.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   start_i                   start (or restart) fetching at RESET_PC
//   imem_req_o, imem_addr_o   memory read request and byte address
//   imem_rdata_i, imem_valid_i memory read data and strobe
//   cu_instr_o, cu_input_en_o instruction to the control unit and its qualifier
//   stall_i                   control unit busy
//   branch_i, branch_target_i taken branch and its target
//   self_instruct_i/_en_i     follow-up instruction to inject
//   end_program_i             stop request
//   pc_o, instr_count_o       current fetch PC, decodes completed
//   halted_o, err_o           halted flag, sticky error flag
//   dbg_state_o               current FSM state (IDLE=0 FETCH=1 ISSUE=2
//                             INJECT=3 HALT=4) for observation
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic [15:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic [15:0] cu_instr_o,
  output logic        cu_input_en_o,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [15:0] branch_target_i,
  input  logic [15:0] self_instruct_i,
  input  logic        self_instruct_en_i,
  input  logic        end_program_i,
  output logic [15:0] pc_o,
  output logic [15:0] instr_count_o,
  output logic        halted_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_INJECT = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_self;
  logic [15:0] r_count;
  logic [15:0] r_wait;
  logic        r_err;

  logic        w_fetch;
  logic        w_issue;
  logic [15:0] w_branch_pc;

  // Outputs are decoded from registered state; only the issue qualifier also
  // looks at stall_i, because a stall has to withhold the offer in the very
  // cycle it is raised.
  assign w_fetch     = (r_state == S_FETCH);
  assign w_issue     = ((r_state == S_ISSUE) || (r_state == S_INJECT)) && !stall_i;
  assign w_branch_pc = {branch_target_i[15:1], 1'b0};

  assign imem_req_o    = w_fetch;
  assign imem_addr_o   = w_fetch ? r_pc : 16'h0000;
  assign cu_input_en_o = w_issue;
  assign cu_instr_o    = !w_issue ? 16'h0000 :
                         (r_state == S_INJECT) ? r_self : r_ir;
  assign pc_o          = r_pc;
  assign instr_count_o = r_count;
  assign halted_o      = (r_state == S_HALT);
  assign err_o         = r_err;
  assign dbg_state_o   = r_state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 16'h0000;
      r_self  <= 16'h0000;
      r_count <= 16'h0000;
      r_wait  <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start_i) begin
            r_pc    <= RESET_PC;
            r_count <= 16'h0000;
            r_err   <= 1'b0;
            r_wait  <= 16'h0000;
            r_state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (imem_valid_i) begin
            r_ir    <= imem_rdata_i;
            r_pc    <= r_pc + 16'd2;
            r_wait  <= 16'h0000;
            r_state <= S_ISSUE;
          end else if (r_wait == TIMEOUT_LAST) begin
            // Last permitted empty cycle: give up and park with the error set.
            r_err   <= 1'b1;
            r_wait  <= 16'h0000;
            r_state <= S_HALT;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end

        S_ISSUE: begin
          if (!stall_i) begin
            r_count <= r_count + 16'd1;
            if (end_program_i) begin
              r_state <= S_HALT;
            end else if (self_instruct_en_i) begin
              r_self  <= self_instruct_i;
              r_state <= S_INJECT;
            end else if (branch_i) begin
              r_pc    <= w_branch_pc;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end

        S_INJECT: begin
          if (!stall_i) begin
            r_count <= r_count + 16'd1;
            // A follow-up cannot request another follow-up; flag it and move on.
            if (self_instruct_en_i) begin
              r_err <= 1'b1;
            end
            if (branch_i) begin
              r_pc <= w_branch_pc;
            end
            r_state <= S_FETCH;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [15:0] RESET_PC    = 16'h0000;
  localparam int          MEM_TIMEOUT = 16;

  // ---------------------------------------------------------------- signals
  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        start_i = 1'b0;
  logic        imem_valid_i = 1'b0;
  logic [15:0] imem_rdata_i = 16'h0000;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [15:0] branch_target_i = 16'h0000;
  logic [15:0] self_instruct_i = 16'h0000;
  logic        self_instruct_en_i = 1'b0;
  logic        end_program_i = 1'b0;

  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [15:0] cu_instr_o;
  logic        cu_input_en_o;
  logic [15:0] pc_o;
  logic [15:0] instr_count_o;
  logic        halted_o;
  logic        err_o;
  logic [2:0]  dbg_state_o;

  instr_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk_i             (clk_i),
    .rst_n_i           (rst_n_i),
    .start_i           (start_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_rdata_i      (imem_rdata_i),
    .imem_valid_i      (imem_valid_i),
    .cu_instr_o        (cu_instr_o),
    .cu_input_en_o     (cu_input_en_o),
    .stall_i           (stall_i),
    .branch_i          (branch_i),
    .branch_target_i   (branch_target_i),
    .self_instruct_i   (self_instruct_i),
    .self_instruct_en_i(self_instruct_en_i),
    .end_program_i     (end_program_i),
    .pc_o              (pc_o),
    .instr_count_o     (instr_count_o),
    .halted_o          (halted_o),
    .err_o             (err_o),
    .dbg_state_o       (dbg_state_o)
  );

  // ------------------------------------------------------- clock and reset
  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------- counters
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------- memory responder
  logic [15:0] mem [0:63];
  int          mem_lat = 0;
  bit          mem_en  = 1'b1;
  int          wait_cnt = 0;

  always @(posedge clk_i) begin
    #1;
    if (imem_req_o && mem_en) begin
      if (wait_cnt >= mem_lat) begin
        imem_valid_i = 1'b1;
        imem_rdata_i = mem[imem_addr_o[6:1]];
        wait_cnt     = 0;
      end else begin
        imem_valid_i = 1'b0;
        imem_rdata_i = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      // Stray strobes while nothing is requested must be ignored.
      imem_valid_i = imem_req_o ? 1'b0 : 1'($urandom_range(0, 1));
      imem_rdata_i = 16'($urandom);
      wait_cnt     = 0;
    end
  end

  // ------------------------------------------------- control-unit responder
  typedef struct {
    int          stall;
    logic        end_p;
    logic        self_en;
    logic [15:0] self_w;
    logic        br;
    logic [15:0] tgt;
  } resp_t;

  resp_t resp_q[$];
  resp_t cur;
  bit    have_cur = 1'b0;

  function automatic resp_t mk(input int stall, input logic end_p, input logic self_en,
                               input logic [15:0] self_w, input logic br, input logic [15:0] tgt);
    resp_t r;
    r.stall = stall; r.end_p = end_p; r.self_en = self_en;
    r.self_w = self_w; r.br = br; r.tgt = tgt;
    return r;
  endfunction

  task automatic drive_noise();
    branch_i           = 1'($urandom_range(0, 1));
    end_program_i      = 1'($urandom_range(0, 1));
    self_instruct_en_i = 1'($urandom_range(0, 1));
    branch_target_i    = 16'($urandom);
    self_instruct_i    = 16'($urandom);
  endtask

  // model state (declared here so the responder can follow the model)
  bit          m_active = 1'b0;
  bit          m_pending = 1'b0;
  bit          m_inject = 1'b0;
  bit          m_halted = 1'b0;
  bit          m_err = 1'b0;
  logic [15:0] m_pc = RESET_PC;
  logic [15:0] m_count = 16'h0000;
  int          m_miss = 0;
  int          req_run = 0;
  int          stall_run = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk_i) begin
    #1;
    if (!rst_n_i) begin
      have_cur = 1'b0;
      stall_i  = 1'b0;
      drive_noise();
    end else if (m_pending) begin
      if (!have_cur) begin
        if (resp_q.size() > 0) cur = resp_q.pop_front();
        else                   cur = mk(0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        have_cur = 1'b1;
      end
      if (cur.stall > 0) begin
        stall_i = 1'b1;
        cur.stall--;
        drive_noise();
      end else begin
        stall_i            = 1'b0;
        end_program_i      = cur.end_p;
        self_instruct_en_i = cur.self_en;
        self_instruct_i    = cur.self_w;
        branch_i           = cur.br;
        branch_target_i    = cur.tgt;
        have_cur           = 1'b0;
      end
    end else begin
      stall_i = 1'($urandom_range(0, 1));
      drive_noise();
    end
  end

  // ----------------------------------------- behavioural model + compare
  logic [15:0] issue_log[$];
  logic [15:0] fetch_log[$];
  int          reqcyc_log[$];
  int          stall_log[$];
  int          tmo_log[$];
  bit          c_req;
  bit          c_en;
  logic [15:0] c_instr;

  task automatic model_reset();
    m_active = 1'b0; m_pending = 1'b0; m_inject = 1'b0;
    m_halted = 1'b0; m_err = 1'b0;
    m_pc = RESET_PC; m_count = 16'h0000;
    m_miss = 0; req_run = 0; stall_run = 0;
    exp_q.delete();
  endtask

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      check("rst_req",    16'(imem_req_o), 16'h0000);
      check("rst_addr",   imem_addr_o, 16'h0000);
      check("rst_en",     16'(cu_input_en_o), 16'h0000);
      check("rst_instr",  cu_instr_o, 16'h0000);
      check("rst_pc",     pc_o, RESET_PC);
      check("rst_count",  instr_count_o, 16'h0000);
      check("rst_halted", 16'(halted_o), 16'h0000);
      check("rst_err",    16'(err_o), 16'h0000);
      model_reset();
    end else begin
      c_req = m_active && !m_pending && !m_halted;
      c_en  = m_pending && !stall_i;
      c_instr = (exp_q.size() > 0) ? exp_q[0] : 16'hDEAD;
      check("req", 16'(imem_req_o), 16'(c_req));
      if (c_req) check("addr", imem_addr_o, m_pc);
      check("en", 16'(cu_input_en_o), 16'(c_en));
      if (c_en) check("instr", cu_instr_o, c_instr);
      else      check("instr_quiet", cu_instr_o, 16'h0000);
      check("pc", pc_o, m_pc);
      check("count", instr_count_o, m_count);
      check("halted", 16'(halted_o), 16'(m_halted));
      check("err", 16'(err_o), 16'(m_err));

      // advance the model by what this cycle means
      if (start_i && (!m_active || m_halted)) begin
        model_reset();
        m_active = 1'b1;
      end else if (c_req) begin
        req_run++;
        if (imem_valid_i) begin
          fetch_log.push_back(m_pc);
          reqcyc_log.push_back(req_run);
          exp_q.push_back(imem_rdata_i);
          req_run = 0; m_miss = 0;
          m_pc = m_pc + 16'd2;
          m_pending = 1'b1; m_inject = 1'b0;
        end else begin
          m_miss++;
          if (m_miss == MEM_TIMEOUT) begin
            tmo_log.push_back(req_run);
            req_run = 0; m_miss = 0;
            m_halted = 1'b1; m_err = 1'b1;
          end
        end
      end else if (m_pending) begin
        if (stall_i) begin
          stall_run++;
        end else begin
          if (cu_input_en_o) issue_log.push_back(cu_instr_o);
          stall_log.push_back(stall_run);
          stall_run = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_count = m_count + 16'd1;
          if (!m_inject) begin
            if (end_program_i) begin
              m_halted = 1'b1; m_pending = 1'b0;
            end else if (self_instruct_en_i) begin
              exp_q.push_front(self_instruct_i);
              m_inject = 1'b1;
            end else begin
              if (branch_i) m_pc = branch_target_i & 16'hFFFE;
              m_pending = 1'b0;
            end
          end else begin
            if (self_instruct_en_i) m_err = 1'b1;
            if (branch_i) m_pc = branch_target_i & 16'hFFFE;
            m_pending = 1'b0; m_inject = 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic do_start();
    @(posedge clk_i); #1; start_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!m_halted && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check("halt_reached", 16'(halted_o), 16'h0001);
  endtask

  task automatic clear_logs();
    issue_log.delete(); fetch_log.delete(); reqcyc_log.delete();
    stall_log.delete(); tmo_log.delete(); resp_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk_i); #3;
    rst_n_i = 1'b0;
    #1;
    check("async_req",    16'(imem_req_o), 16'h0000);
    check("async_en",     16'(cu_input_en_o), 16'h0000);
    check("async_instr",  cu_instr_o, 16'h0000);
    check("async_pc",     pc_o, 16'h0000);
    check("async_count",  instr_count_o, 16'h0000);
    check("async_halted", 16'(halted_o), 16'h0000);
    check("async_state",  16'(dbg_state_o), 16'h0000);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0]  = 16'h2005;
    mem[1]  = 16'h1234;
    mem[32] = 16'h5678;
    mem[33] = 16'h3333;

    #1 rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    repeat (3) @(posedge clk_i);   // no start yet: must stay idle

    // Run 1: wait states, branch, injection, stall, end+branch
    clear_logs();
    mem_en = 1'b1; mem_lat = 2;
    resp_q.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000));
    resp_q.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0041));
    resp_q.push_back(mk(0, 1'b0, 1'b1, 16'h9701, 1'b0, 16'h0000));
    resp_q.push_back(mk(1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000));
    resp_q.push_back(mk(3, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041));
    do_start();
    wait_halt(300);
    check("r1_first_req_cycles", 16'(reqcyc_log[0]), 16'd3);
    check("r1_fetch0", fetch_log[0], 16'h0000);
    check("r1_fetch1", fetch_log[1], 16'h0002);
    check("r1_fetch2", fetch_log[2], 16'h0040);
    check("r1_fetch3", fetch_log[3], 16'h0042);
    check("r1_issues", 16'(issue_log.size()), 16'd5);
    check("r1_issue0", issue_log[0], 16'h2005);
    check("r1_issue2", issue_log[2], 16'h5678);
    check("r1_issue3", issue_log[3], 16'h9701);
    check("r1_issue4", issue_log[4], 16'h3333);
    check("r1_stall4", 16'(stall_log[4]), 16'd3);
    check("r1_pc", pc_o, 16'h0044);
    check("r1_count", instr_count_o, 16'd5);
    repeat (4) @(posedge clk_i);   // halted: no further requests

    // Run 2: memory never answers
    clear_logs();
    mem_en = 1'b0;
    do_start();
    wait_halt(100);
    check("r2_timeout_cycles", 16'(tmo_log[0]), 16'd16);
    check("r2_err", 16'(err_o), 16'h0001);
    check("r2_pc", pc_o, 16'h0000);
    check("r2_count", instr_count_o, 16'h0000);

    // Run 3: nested injection request, end_program ignored in inject
    clear_logs();
    mem_en = 1'b1; mem_lat = 0;
    resp_q.push_back(mk(0, 1'b0, 1'b1, 16'h9701, 1'b0, 16'h0000));
    resp_q.push_back(mk(2, 1'b1, 1'b1, 16'hBEEF, 1'b1, 16'h0041));
    resp_q.push_back(mk(0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000));
    resp_q.push_back(mk(0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000));
    do_start();
    check("r3_err_cleared", 16'(err_o), 16'h0000);
    wait_halt(200);
    check("r3_issues", 16'(issue_log.size()), 16'd4);
    check("r3_issue1", issue_log[1], 16'h9701);
    check("r3_issue2", issue_log[2], 16'h5678);
    check("r3_fetch1", fetch_log[1], 16'h0040);
    check("r3_err", 16'(err_o), 16'h0001);
    check("r3_pc", pc_o, 16'h0044);
    check("r3_count", instr_count_o, 16'd4);

    // Run 4: reset while an injection is stalled
    clear_logs();
    mem_lat = 1;
    resp_q.push_back(mk(0, 1'b0, 1'b1, 16'h9701, 1'b0, 16'h0000));
    resp_q.push_back(mk(30, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000));
    do_start();
    begin
      int n = 0;
      while (!(m_pending && m_inject) && n < 50) begin
        @(posedge clk_i);
        n++;
      end
    end
    repeat (2) @(posedge clk_i);
    #1 check("r4_in_inject", 16'(dbg_state_o), 16'd3);
    resp_q.delete();
    pulse_reset();
    repeat (4) @(posedge clk_i);
    #1 check("r4_stays_idle", 16'(imem_req_o), 16'h0000);

    // Run 5: restart after reset
    clear_logs();
    resp_q.push_back(mk(0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000));
    do_start();
    wait_halt(100);
    check("r5_issue0", issue_log[0], 16'h2005);
    check("r5_count", instr_count_o, 16'd1);
    check("r5_pc", pc_o, 16'h0002);
    check("r5_err", 16'(err_o), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
